// File: rtl/crc_share_ctrl.sv
// crc_share_ctrl: round-robin sharing of one byte-serial CRC-8 engine (generate/check) between two requesters
// Ports: CLK/RESET (sync, active-high); POLY generator low bits, latched at grant;
//   REQx/DINx/MODEx/CRCINx requester inputs; GNTx combinational accept pulse;
//   DONEx one-cycle completion pulse to the owner; CRC_OUT/ERR result held until the next DONE;
//   BUSY high while not IDLE; ERR_CNT saturating mismatch count.
// Optional: define CRC_ERRCNT_EN to build the ERR_CNT counter; otherwise ERR_CNT is tied to 0.
module crc_share_ctrl #(
  parameter int DATA_W = 32,
  parameter int CRC_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [CRC_W-1:0]  POLY,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] DIN0,
  input  logic              MODE0,
  input  logic [CRC_W-1:0]  CRCIN0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DIN1,
  input  logic              MODE1,
  input  logic [CRC_W-1:0]  CRCIN1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic [CRC_W-1:0]  CRC_OUT,
  output logic              ERR,
  output logic              BUSY,
  output logic [7:0]        ERR_CNT
);
  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mode_q, mode_d;
  logic [CRC_W-1:0]  crcin_q, crcin_d, poly_q, poly_d, acc_q, acc_d;
  logic [CRC_W-1:0]  crc_out_q, crc_out_d;
  logic              err_q, err_d, done0_q, done0_d, done1_q, done1_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              idle, pick1, mismatch;

  // MSB-first shift/XOR over one byte; no reflection, no final XOR
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] a, input logic [7:0] b,
                                            input logic [CRC_W-1:0] p);
    logic [CRC_W-1:0] r;
    r = a;
    for (int i = 7; i >= 0; i--) r = {r[CRC_W-2:0], 1'b0} ^ ((r[CRC_W-1] ^ b[i]) ? p : '0);
    return r;
  endfunction

  assign idle     = state_q == S_IDLE;
  // requester 1 wins when alone, or on a tie when requester 0 was served last
  assign pick1    = REQ1 & (~REQ0 | ~last_q);
  assign GNT0     = idle & REQ0 & ~pick1;
  assign GNT1     = idle & pick1;
  assign mismatch = acc_q != crcin_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    data_d    = data_q;
    mode_d    = mode_q;
    crcin_d   = crcin_q;
    poly_d    = poly_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    crc_out_d = crc_out_q;
    err_d     = err_q;
    done0_d   = (state_q == S_DONE) & ~owner_q;
    done1_d   = (state_q == S_DONE) & owner_q;
    if (idle && (REQ0 || REQ1)) begin
      owner_d = pick1;
      last_d  = pick1;
      data_d  = pick1 ? DIN1 : DIN0;
      mode_d  = pick1 ? MODE1 : MODE0;
      crcin_d = pick1 ? CRCIN1 : CRCIN0;
      poly_d  = POLY;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      // the word is shifted left each cycle so the current byte is always the top one
      acc_d   = fold(acc_q, data_q[DATA_W-1 -: 8], poly_q);
      data_d  = data_q << 8;
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(NB - 1)) ? S_DONE : S_RUN;
    end else if (state_q == S_DONE) begin
      crc_out_d = acc_q;
      err_d     = mode_q & mismatch;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      data_q    <= '0;
      mode_q    <= 1'b0;
      crcin_q   <= '0;
      poly_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      crc_out_q <= '0;
      err_q     <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      crcin_q   <= crcin_d;
      poly_q    <= poly_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      crc_out_q <= crc_out_d;
      err_q     <= err_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
    end
  end

  assign DONE0   = done0_q;
  assign DONE1   = done1_q;
  assign CRC_OUT = crc_out_q;
  assign ERR     = err_q;
  assign BUSY    = ~idle;

`ifdef CRC_ERRCNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge CLK) begin
    if (RESET) err_cnt_q <= '0;
    else if (state_q == S_DONE && mode_q && mismatch && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = '0;
`endif
endmodule

// File: tb/tb_crc_share_ctrl.sv
// tb_crc_share_ctrl: scoreboard bench for crc_share_ctrl with hand-computed CRC-8 (poly 0x97) vectors
module tb_crc_share_ctrl;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic [7:0]  POLY = 8'h97;
  logic        REQ0 = 0, MODE0 = 0, REQ1 = 0, MODE1 = 0;
  logic [31:0] DIN0 = 0, DIN1 = 0;
  logic [7:0]  CRCIN0 = 0, CRCIN1 = 0;
  logic        GNT0, GNT1, DONE0, DONE1, ERR, BUSY;
  logic [7:0]  CRC_OUT, ERR_CNT;

`ifdef CRC_ERRCNT_EN
  localparam logic [7:0] EXP_CNT = 8'd1;
`else
  localparam logic [7:0] EXP_CNT = 8'd0;
`endif

  typedef struct {int id; logic [7:0] crc; logic err; int due;} exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0, cyc = 0;

  crc_share_ctrl dut (
    .CLK(CLK), .RESET(RESET), .POLY(POLY),
    .REQ0(REQ0), .DIN0(DIN0), .MODE0(MODE0), .CRCIN0(CRCIN0),
    .REQ1(REQ1), .DIN1(DIN1), .MODE1(MODE1), .CRCIN1(CRCIN1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .CRC_OUT(CRC_OUT), .ERR(ERR), .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every DONE pops the oldest expected completion
  always @(negedge CLK) begin
    exp_t e;
    if (GNT0 || GNT1) chk("gnt_exclusive", {31'd0, GNT0 & GNT1}, 32'd0);
    if (DONE0 || DONE1) begin
      chk("done_exclusive", {31'd0, DONE0 & DONE1}, 32'd0);
      if (sb.size() == 0) chk("unexpected_done", {30'd0, DONE1, DONE0}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("done_owner", {31'd0, DONE1}, e.id);
        chk("done_cycle", cyc, e.due);
        chk("crc_out", {24'd0, CRC_OUT}, {24'd0, e.crc});
        chk("err", {31'd0, ERR}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // waits for a grant, checks its owner and optionally queues the expected completion
  task automatic wait_gnt(input int id, input bit push, input logic [7:0] ecrc, input logic eerr, output int t);
    bit got = 0;
    t = -1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge CLK);
      if (GNT0 || GNT1) begin
        got = 1;
        t = cyc;
        chk("gnt_owner", {31'd0, GNT1}, id);
        if (push) sb.push_back('{id, ecrc, eerr, cyc + 6});
      end
    end
    if (!got) chk("gnt_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    chk("drain", sb.size(), 0);
    tick();
  endtask

  task automatic do_req(input int id, input logic [31:0] din, input logic mode, input logic [7:0] crcin,
                        input logic [7:0] ecrc, input logic eerr);
    int t;
    if (id == 0) begin DIN0 = din; MODE0 = mode; CRCIN0 = crcin; REQ0 = 1; end
    else begin DIN1 = din; MODE1 = mode; CRCIN1 = crcin; REQ1 = 1; end
    wait_gnt(id, 1, ecrc, eerr, t);
    tick();
    REQ0 = 0; REQ1 = 0;
    DIN0 = 32'hDEAD_BEEF; DIN1 = 32'hDEAD_BEEF;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tp, n;
    tick();
    @(negedge CLK);
    chk("rst_gnt", {30'd0, GNT1, GNT0}, 0);
    chk("rst_done", {30'd0, DONE1, DONE0}, 0);
    chk("rst_crc", {24'd0, CRC_OUT}, 0);
    chk("rst_err", {31'd0, ERR}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_errcnt", {24'd0, ERR_CNT}, 0);
    tick();
    RESET = 0;
    tick();
    do_req(0, 32'h0000_0001, 0, 8'h00, 8'h97, 0);
    do_req(1, 32'h0000_0100, 0, 8'h00, 8'hD3, 0);
    do_req(1, 32'h0000_0002, 0, 8'h00, 8'hB9, 0);
    do_req(1, 32'h0000_0000, 0, 8'h00, 8'h00, 0);
    do_req(0, 32'h0000_0100, 1, 8'hD3, 8'hD3, 0);
    do_req(0, 32'h0000_0100, 1, 8'hD2, 8'hD3, 1);
    chk("err_cnt", {24'd0, ERR_CNT}, {24'd0, EXP_CNT});
    // both requesters held from reset: strict alternation starting with 0
    RESET = 1;
    tick();
    RESET = 0;
    DIN0 = 32'h0000_0001; MODE0 = 0; DIN1 = 32'h0000_0100; MODE1 = 0;
    REQ0 = 1; REQ1 = 1;
    tp = -1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(k % 2, 1, (k % 2) ? 8'hD3 : 8'h97, 0, t0);
      if (tp >= 0) chk("gnt_spacing", t0 - tp, 6);
      tp = t0;
    end
    tick();
    REQ0 = 0; REQ1 = 0;
    drain();
    // reset two cycles after grant aborts the operation
    DIN0 = 32'h0000_0001; REQ0 = 1;
    wait_gnt(0, 0, 8'h00, 0, t0);
    tick();
    REQ0 = 0;
    tick();
    RESET = 1;
    tick();
    RESET = 0;
    @(negedge CLK);
    chk("abort_busy", {31'd0, BUSY}, 0);
    chk("abort_crc", {24'd0, CRC_OUT}, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE0 || DONE1) n++;
      @(negedge CLK);
    end
    chk("abort_no_done", n, 0);
    tick();
    do_req(0, 32'h0000_0002, 0, 8'h00, 8'hB9, 0);
    // REQ1 arriving while busy is granted in the DONE0 cycle
    DIN0 = 32'h0000_0001; MODE0 = 0; REQ0 = 1;
    wait_gnt(0, 1, 8'h97, 0, t0);
    tick();
    REQ0 = 0; DIN1 = 32'h0000_0002; MODE1 = 0; REQ1 = 1;
    wait_gnt(1, 1, 8'hB9, 0, t1);
    chk("busy_wait_gnt", t1 - t0, 6);
    tick();
    REQ1 = 0;
    drain();
    // REQ1 withdrawn before its grant is never served
    DIN0 = 32'h0000_0000; REQ0 = 1;
    wait_gnt(0, 1, 8'h00, 0, t0);
    tick();
    REQ0 = 0; REQ1 = 1;
    tick();
    tick();
    REQ1 = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (GNT1) n++;
    end
    chk("dropped_no_gnt1", n, 0);
    chk("dropped_idle", {31'd0, BUSY}, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
